// File: rtl/video_std_pkg.sv
// Shared types and default timing windows for the composite-video monitor.
// Contents:
//   video_std_t     - detected standard reported on std_out
//   monitor_state_t - lock state machine states
//   DEF_*           - default field-period windows in 50 MHz sys_clk cycles
//   classify_field  - maps a measured field period onto a standard
package video_std_pkg;

    typedef enum logic [1:0] {
        STD_NONE = 2'd0,
        STD_NTSC = 2'd1,
        STD_PAL  = 2'd2
    } video_std_t;

    typedef enum logic [1:0] {
        NO_SIGNAL,
        ACQUIRE,
        LOCKED
    } monitor_state_t;

    localparam int unsigned DEF_NTSC_MIN    = 820_000;
    localparam int unsigned DEF_NTSC_MAX    = 850_000;
    localparam int unsigned DEF_PAL_MIN     = 985_000;
    localparam int unsigned DEF_PAL_MAX     = 1_015_000;
    localparam int unsigned DEF_LOCK_FIELDS = 4;
    localparam int unsigned DEF_MISS_LIMIT  = 2;
    localparam int unsigned DEF_TIMEOUT     = 2_000_000;

    // Window bounds are inclusive; anything outside both windows is STD_NONE (a bad field).
    function automatic video_std_t classify_field(
        input logic [20:0] period,
        input logic [20:0] ntsc_min,
        input logic [20:0] ntsc_max,
        input logic [20:0] pal_min,
        input logic [20:0] pal_max
    );
        if (period >= ntsc_min && period <= ntsc_max) begin
            return STD_NTSC;
        end
        if (period >= pal_min && period <= pal_max) begin
            return STD_PAL;
        end
        return STD_NONE;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Carries a toggle-encoded event from the clk_pixel domain into sys_clk.
// Ports:
//   sys_clk   in  system clock
//   sys_rst   in  asynchronous active-high reset
//   toggle_in in  level that flips once per source event
//   pulse     out one-cycle pulse per flip, 3 sys_clk after the flip
module toggle_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic toggle_in,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic edge_q;

    // sync1/sync2 resolve metastability, edge_q holds the previous settled level;
    // the xor of the last two is registered so the event leaves on a flop.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            edge_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync1  <= toggle_in;
            sync2  <= sync1;
            edge_q <= sync2;
            pulse  <= sync2 ^ edge_q;
        end
    end

endmodule

// File: rtl/video_signal_monitor.sv
// Measures composite-video field timing and reports lock and NTSC/PAL standard.
// Ports:
//   sys_clk      in   50 MHz system clock
//   sys_rst      in   asynchronous active-high reset
//   hsync_toggle in   flips once per h sync pulse (clk_pixel domain)
//   vsync_toggle in   flips once per v sync pulse (clk_pixel domain)
//   video_locked out  stable standard detected
//   std_out      out  video_std_t of the locked standard, STD_NONE otherwise
//   field_period out  last measured field period in sys_clk cycles (saturating)
//   line_count   out  h events in the last field (saturating at 1023)
//   status_valid out  one-cycle pulse when field_period/line_count update
module video_signal_monitor
    import video_std_pkg::*;
#(
    parameter int unsigned NTSC_MIN    = DEF_NTSC_MIN,
    parameter int unsigned NTSC_MAX    = DEF_NTSC_MAX,
    parameter int unsigned PAL_MIN     = DEF_PAL_MIN,
    parameter int unsigned PAL_MAX     = DEF_PAL_MAX,
    parameter int unsigned LOCK_FIELDS = DEF_LOCK_FIELDS,
    parameter int unsigned MISS_LIMIT  = DEF_MISS_LIMIT,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        hsync_toggle,
    input  logic        vsync_toggle,
    output logic        video_locked,
    output logic [1:0]  std_out,
    output logic [20:0] field_period,
    output logic [9:0]  line_count,
    output logic        status_valid
);

    localparam logic [20:0] NTSC_MIN_P = 21'(NTSC_MIN);
    localparam logic [20:0] NTSC_MAX_P = 21'(NTSC_MAX);
    localparam logic [20:0] PAL_MIN_P  = 21'(PAL_MIN);
    localparam logic [20:0] PAL_MAX_P  = 21'(PAL_MAX);
    localparam logic [20:0] TIMEOUT_P  = 21'(TIMEOUT);
    localparam logic [7:0]  LOCK_P     = 8'(LOCK_FIELDS);
    localparam logic [7:0]  MISS_P     = 8'(MISS_LIMIT);

    logic h_ev;
    logic v_ev;

    toggle_sync u_h_sync (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .toggle_in (hsync_toggle),
        .pulse     (h_ev)
    );

    toggle_sync u_v_sync (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .toggle_in (vsync_toggle),
        .pulse     (v_ev)
    );

    monitor_state_t state_q, state_d;
    video_std_t     cand_q, cand_d;
    video_std_t     std_q, std_d;
    logic [7:0]     match_q, match_d;
    logic [7:0]     miss_q, miss_d;
    logic           locked_q, locked_d;
    logic [20:0]    period_cnt_q, period_cnt_d;
    logic [9:0]     line_cnt_q, line_cnt_d;
    logic [20:0]    field_period_q, field_period_d;
    logic [9:0]     line_count_q, line_count_d;
    logic           valid_q, valid_d;

    video_std_t     cls;
    logic [9:0]     h_sum;
    logic [7:0]     match_inc;
    logic [7:0]     miss_inc;
    logic           timeout;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= NO_SIGNAL;
            cand_q         <= STD_NONE;
            std_q          <= STD_NONE;
            match_q        <= '0;
            miss_q         <= '0;
            locked_q       <= 1'b0;
            period_cnt_q   <= '0;
            line_cnt_q     <= '0;
            field_period_q <= '0;
            line_count_q   <= '0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cand_q         <= cand_d;
            std_q          <= std_d;
            match_q        <= match_d;
            miss_q         <= miss_d;
            locked_q       <= locked_d;
            period_cnt_q   <= period_cnt_d;
            line_cnt_q     <= line_cnt_d;
            field_period_q <= field_period_d;
            line_count_q   <= line_count_d;
            valid_q        <= valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cand_d         = cand_q;
        std_d          = std_q;
        match_d        = match_q;
        miss_d         = miss_q;
        locked_d       = locked_q;
        field_period_d = field_period_q;
        line_count_d   = line_count_q;
        valid_d        = 1'b0;

        period_cnt_d = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + 21'd1;
        // An h event coinciding with the v event belongs to the field that is ending.
        h_sum        = (h_ev && line_cnt_q != '1) ? line_cnt_q + 10'd1 : line_cnt_q;
        line_cnt_d   = h_sum;

        cls       = classify_field(period_cnt_q, NTSC_MIN_P, NTSC_MAX_P, PAL_MIN_P, PAL_MAX_P);
        match_inc = (cls == cand_q) ? match_q + 8'd1 : 8'd1;
        miss_inc  = miss_q + 8'd1;
        timeout   = (period_cnt_q >= TIMEOUT_P);

        if (timeout) begin
            // Counters restart so a fresh v event is not masked by a stale timeout.
            state_d        = NO_SIGNAL;
            cand_d         = STD_NONE;
            std_d          = STD_NONE;
            match_d        = '0;
            miss_d         = '0;
            locked_d       = 1'b0;
            field_period_d = '1;
            line_count_d   = '0;
            period_cnt_d   = '0;
            line_cnt_d     = '0;
        end else if (v_ev) begin
            period_cnt_d = 21'd1;
            line_cnt_d   = '0;
            if (state_q != NO_SIGNAL) begin
                valid_d        = 1'b1;
                field_period_d = period_cnt_q;
                line_count_d   = h_sum;
            end
            case (state_q)
                NO_SIGNAL: begin
                    state_d = ACQUIRE;
                    cand_d  = STD_NONE;
                    match_d = '0;
                    miss_d  = '0;
                end
                ACQUIRE: begin
                    if (cls == STD_NONE) begin
                        cand_d  = STD_NONE;
                        match_d = '0;
                    end else begin
                        cand_d  = cls;
                        match_d = match_inc;
                        if (match_inc >= LOCK_P) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            std_d    = cls;
                            miss_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (cls == std_q) begin
                        miss_d = '0;
                    end else if (miss_inc >= MISS_P) begin
                        state_d  = ACQUIRE;
                        locked_d = 1'b0;
                        std_d    = STD_NONE;
                        cand_d   = STD_NONE;
                        match_d  = '0;
                        miss_d   = '0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
                default: begin
                    state_d = NO_SIGNAL;
                end
            endcase
        end
    end

    assign video_locked = locked_q;
    assign std_out      = std_q;
    assign field_period = field_period_q;
    assign line_count   = line_count_q;
    assign status_valid = valid_q;

endmodule

// File: tb/tb_video_signal_monitor.sv
// Self-checking bench for video_signal_monitor with field windows scaled by 1/1000.
module tb_video_signal_monitor;

    localparam int NTSC_MIN    = 820;
    localparam int NTSC_MAX    = 850;
    localparam int PAL_MIN     = 985;
    localparam int PAL_MAX     = 1015;
    localparam int LOCK_FIELDS = 4;
    localparam int MISS_LIMIT  = 2;
    localparam int TIMEOUT     = 2000;
    localparam int FP_SAT      = 2097151;

    logic        sys_clk;
    logic        sys_rst;
    logic        hsync_toggle;
    logic        vsync_toggle;
    logic        video_locked;
    logic [1:0]  std_out;
    logic [20:0] field_period;
    logic [9:0]  line_count;
    logic        status_valid;

    video_signal_monitor #(
        .NTSC_MIN    (NTSC_MIN),
        .NTSC_MAX    (NTSC_MAX),
        .PAL_MIN     (PAL_MIN),
        .PAL_MAX     (PAL_MAX),
        .LOCK_FIELDS (LOCK_FIELDS),
        .MISS_LIMIT  (MISS_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .hsync_toggle (hsync_toggle),
        .vsync_toggle (vsync_toggle),
        .video_locked (video_locked),
        .std_out      (std_out),
        .field_period (field_period),
        .line_count   (line_count),
        .status_valid (status_valid)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: history of field classes, lock flag and miss run.
    bit m_idle;
    bit exp_valid;
    int exp_fp;
    int exp_lc;
    int exp_locked;
    int exp_std;
    int misses;
    int hist[$];
    int prev_period;
    int prev_lines;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int classify(input int p);
        if (p >= NTSC_MIN && p <= NTSC_MAX) return 1;
        if (p >= PAL_MIN && p <= PAL_MAX) return 2;
        return 0;
    endfunction

    task automatic model_clear(input int fp);
        m_idle     = 1'b1;
        exp_valid  = 1'b0;
        exp_fp     = fp;
        exp_lc     = 0;
        exp_locked = 0;
        exp_std    = 0;
        misses     = 0;
        hist.delete();
    endtask

    task automatic model_v_event(input int period, input int lines);
        int  cls;
        bit  same;
        if (m_idle) begin
            m_idle    = 1'b0;
            exp_valid = 1'b0;
            hist.delete();
            return;
        end
        exp_valid = 1'b1;
        exp_fp    = period;
        exp_lc    = (lines > 1023) ? 1023 : lines;
        cls       = classify(period);
        if (exp_locked == 0) begin
            hist.push_back(cls);
            if (hist.size() >= LOCK_FIELDS && cls != 0) begin
                same = 1'b1;
                for (int i = 0; i < LOCK_FIELDS; i++)
                    if (hist[hist.size() - 1 - i] != cls) same = 1'b0;
                if (same) begin
                    exp_locked = 1;
                    exp_std    = cls;
                    misses     = 0;
                    hist.delete();
                end
            end
        end else if (cls == exp_std) begin
            misses = 0;
        end else begin
            misses++;
            if (misses >= MISS_LIMIT) begin
                exp_locked = 0;
                exp_std    = 0;
                misses     = 0;
                hist.delete();
            end
        end
    endtask

    task automatic check_outputs();
        check("status_valid", status_valid, exp_valid);
        check("field_period", field_period, exp_fp);
        check("line_count",   line_count,   exp_lc);
        check("video_locked", video_locked, exp_locked);
        check("std_out",      std_out,      exp_std);
    endtask

    // Called #1 after a posedge; flips vsync now, and h toggles fill the field.
    task automatic drive_field(input int period, input int lines, input bit hv_same);
        int step;
        step = (2 * lines <= period - 2) ? 2 : 1;
        vsync_toggle = ~vsync_toggle;
        if (hv_same) hsync_toggle = ~hsync_toggle;
        model_v_event(prev_period, prev_lines + (hv_same ? 1 : 0));
        for (int c = 1; c < period; c++) begin
            @(posedge sys_clk); #1;
            if (c == 3) check("valid_early", status_valid, 1'b0);
            if (c == 4) check_outputs();
            if (c == 5) check("valid_width", status_valid, 1'b0);
            if (c <= lines * step && (c % step) == 0) hsync_toggle = ~hsync_toggle;
        end
        @(posedge sys_clk); #1;
        prev_period = period;
        prev_lines  = lines;
    endtask

    task automatic timeout_test();
        vsync_toggle = ~vsync_toggle;
        model_v_event(prev_period, prev_lines);
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            @(posedge sys_clk); #1;
            if (c == 4) check_outputs();
            if (c == TIMEOUT + 3) check("locked_before_timeout", video_locked, exp_locked);
            if (c == TIMEOUT + 4) begin
                model_clear(FP_SAT);
                check("to_locked",       video_locked, 1'b0);
                check("to_std",          std_out,      2'd0);
                check("to_line_count",   line_count,   10'd0);
                check("to_field_period", field_period, FP_SAT);
                check("to_valid",        status_valid, 1'b0);
            end
        end
    endtask

    task automatic mid_reset();
        #2;
        sys_rst = 1'b1;
        #1;
        check("rst_locked",       video_locked, 1'b0);
        check("rst_std",          std_out,      2'd0);
        check("rst_field_period", field_period, 21'd0);
        check("rst_line_count",   line_count,   10'd0);
        check("rst_valid",        status_valid, 1'b0);
        hsync_toggle = 1'b0;
        vsync_toggle = 1'b0;
        model_clear(0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    function automatic int max_lines(input int p);
        int m;
        m = (p - 2) / 2;
        return (m > 400) ? 400 : m;
    endfunction

    int kind;
    int per;

    initial begin
        sys_rst      = 1'b1;
        hsync_toggle = 1'b0;
        vsync_toggle = 1'b0;
        prev_period  = 0;
        prev_lines   = 0;
        model_clear(0);
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_locked",       video_locked, 1'b0);
        check("reset_std",          std_out,      2'd0);
        check("reset_field_period", field_period, 21'd0);
        check("reset_line_count",   line_count,   10'd0);
        check("reset_valid",        status_valid, 1'b0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        // Nominal NTSC: lock reported on the 5th v toggle.
        repeat (6) drive_field(834, 263, 1'b0);
        check("ntsc_locked", video_locked, 1'b1);
        check("ntsc_std",    std_out,      2'd1);
        repeat (3) begin
            per = $urandom_range(NTSC_MIN, NTSC_MAX);
            drive_field(per, $urandom_range(50, max_lines(per)), 1'b0);
        end

        // One bad field tolerated, two consecutive drop lock, then relock.
        drive_field(500, 200, 1'b0);
        drive_field(834, 263, 1'b0);
        drive_field(834, 263, 1'b0);
        drive_field(500, 200, 1'b0);
        drive_field(600, 250, 1'b0);
        drive_field(834, 263, 1'b0);
        repeat (4) drive_field(834, 263, 1'b0);

        // Coincident h/v toggles, then line count saturation.
        drive_field(834, 263, 1'b1);
        drive_field(834, 263, 1'b0);
        drive_field(1101, 1100, 1'b0);
        drive_field(834, 263, 1'b0);
        drive_field(834, 263, 1'b0);

        timeout_test();

        // PAL lock, then reset mid-field.
        repeat (5) drive_field(1000, 313, 1'b0);
        check("pal_locked", video_locked, 1'b1);
        check("pal_std",    std_out,      2'd2);
        repeat (2) begin
            per = $urandom_range(PAL_MIN, PAL_MAX);
            drive_field(per, $urandom_range(50, max_lines(per)), 1'b0);
        end
        drive_field(1000, 313, 1'b0);
        mid_reset();

        // Just outside the PAL window never locks; inclusive bounds do.
        repeat (3) begin
            drive_field(984, 300, 1'b0);
            drive_field(1016, 300, 1'b0);
        end
        repeat (3) begin
            drive_field(985, 300, 1'b0);
            drive_field(1015, 300, 1'b0);
        end
        repeat (3) begin
            drive_field(820, 263, 1'b0);
            drive_field(850, 263, 1'b0);
        end

        // Random field stream with sticky standard choice.
        kind = 0;
        repeat (16) begin
            if ($urandom_range(0, 3) == 0) kind = $urandom_range(0, 4);
            case (kind)
                0:       per = $urandom_range(NTSC_MIN, NTSC_MAX);
                1:       per = $urandom_range(PAL_MIN, PAL_MAX);
                2:       per = $urandom_range(600, NTSC_MIN - 1);
                3:       per = $urandom_range(NTSC_MAX + 1, PAL_MIN - 1);
                default: per = $urandom_range(PAL_MAX + 1, 1300);
            endcase
            drive_field(per, $urandom_range(50, max_lines(per)), ($urandom_range(0, 3) == 0));
        end
        drive_field(834, 263, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
